// File: rtl/game_controller.sv
// Game flow controller: sequences serve, play, pause, win and game-over states,
// derives the ball step tick from clk, and keeps the cleared-block score.
module game_controller #(
  parameter int TICK_DIV    = 500000,
  parameter int SERVE_TICKS = 60,
  parameter int NUM_BLOCKS  = 56
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            lives,
  input  logic [NUM_BLOCKS-1:0] visible,
  output logic                  step_tick,
  output logic                  ball_reset,
  output logic                  life_lost,
  output logic [2:0]            game_state,
  output logic [7:0]            score
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SERVE  = 3'd1,
    PLAY   = 3'd2,
    WIN    = 3'd3,
    OVER   = 3'd4,
    PAUSED = 3'd5
  } state_t;

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SRV_W = (SERVE_TICKS > 0) ? $clog2(SERVE_TICKS + 1) : 1;
  localparam int CNT_W = $clog2(NUM_BLOCKS + 1);

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(TICK_DIV - 1);
  localparam logic [SRV_W-1:0] SERVE_LOAD = SRV_W'(SERVE_TICKS);
  localparam logic [SRV_W-1:0] SERVE_ONE  = SRV_W'(1);
  localparam logic [8:0]       SCORE_MAX  = 9'(NUM_BLOCKS);

  state_t                  state, state_nx;
  logic [DIV_W-1:0]        div_q, div_nx;
  logic [SRV_W-1:0]        serve_q, serve_nx;
  logic                    start_q;
  logic [1:0]              lives_q;
  logic [NUM_BLOCKS-1:0]   visible_q;
  logic [7:0]              score_nx;
  logic [8:0]              score_sum;
  logic [CNT_W-1:0]        cleared;
  logic                    press, running, tick, loss, win;

  assign press      = start & ~start_q;
  assign running    = (state == SERVE) || (state == PLAY);
  assign tick       = running && (div_q == DIV_LAST);
  assign loss       = (state == PLAY) && (lives < lives_q);
  assign win        = (state == PLAY) && (visible == '0);
  assign game_state = state;

  // Blocks that were present last cycle and are gone now.
  always_comb begin
    cleared = '0;
    for (int i = 0; i < NUM_BLOCKS; i++) begin
      cleared = cleared + CNT_W'(visible_q[i] & ~visible[i]);
    end
  end

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    state_nx = state;
    unique case (state)
      IDLE:   if (press) state_nx = SERVE;
      SERVE:  if (tick && (serve_q == SERVE_ONE || serve_q == '0)) state_nx = PLAY;
      PLAY: begin
        if (win)       state_nx = WIN;
        else if (loss) state_nx = (lives == 2'd0) ? OVER : SERVE;
        else if (press) state_nx = PAUSED;
      end
      PAUSED: if (press) state_nx = PLAY;
      WIN, OVER: if (press) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    div_nx = div_q;
    if (running)               div_nx = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    else if (state != PAUSED)  div_nx = '0;

    serve_nx = serve_q;
    if (state_nx == SERVE && state != SERVE)               serve_nx = SERVE_LOAD;
    else if (state == SERVE && tick && serve_q != '0)      serve_nx = serve_q - 1'b1;

    score_sum = {1'b0, score} + 9'(cleared);
    score_nx  = score;
    if (state == IDLE && press)
      score_nx = '0;
    else if (running || state == PAUSED)
      score_nx = (score_sum > SCORE_MAX) ? SCORE_MAX[7:0] : score_sum[7:0];
  end

  // lives_q follows the input even in reset so a stale value never reads as a loss.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      div_q      <= '0;
      serve_q    <= '0;
      start_q    <= 1'b0;
      lives_q    <= lives;
      visible_q  <= '1;
      score      <= '0;
      step_tick  <= 1'b0;
      ball_reset <= 1'b0;
      life_lost  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state      <= state_nx;
      div_q      <= div_nx;
      serve_q    <= serve_nx;
      start_q    <= start;
      lives_q    <= lives;
      visible_q  <= visible;
      score      <= score_nx;
      step_tick  <= (state_nx == PLAY) && (div_nx == DIV_LAST);
      ball_reset <= (state_nx == SERVE) && (state != SERVE);
      life_lost  <= loss;
    end
  end

endmodule

// File: doc/game_controller.md
GAME_CONTROLLER -- requirements
Module: game_controller

Interface
REQ-001 Parameter TICK_DIV, default 500000, is the number of clk cycles per ball step tick.
REQ-002 Parameter SERVE_TICKS, default 60, is the number of step ticks the ball is held after a serve before play resumes.
REQ-003 Parameter NUM_BLOCKS, default 56, is the width of the block visibility vector.
REQ-004 clk  input  1  system clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  debounced start/pause button level, synchronous to clk.
REQ-007 lives  input  2  remaining lives reported by the ball block.
REQ-008 visible  input  NUM_BLOCKS  block visibility, 1 = block present.
REQ-009 step_tick  output  1  one-cycle pulse; advances the ball one step; asserted only in PLAY.
REQ-010 ball_reset  output  1  one-cycle pulse that re-centres the ball on the paddle.
REQ-011 life_lost  output  1  one-cycle pulse on each detected loss of a life.
REQ-012 game_state  output  3  IDLE=0, SERVE=1, PLAY=2, WIN=3, OVER=4, PAUSED=5.
REQ-013 score  output  8  count of blocks cleared since last game start, saturating at NUM_BLOCKS.

Function
REQ-014 start is edge-detected with a registered copy; a press is a 0->1 transition; holding start produces exactly one press.
REQ-015 Divider counts 0..TICK_DIV-1 in SERVE and PLAY, wraps to 0, and generates an internal tick on the wrap cycle; it holds its value in PAUSED and clears to 0 in IDLE, WIN, OVER.
REQ-016 step_tick equals the internal tick gated by state==PLAY.
REQ-017 IDLE: on press -> SERVE; score cleared to 0 on this transition.
REQ-018 SERVE entry: ball_reset pulses on the first cycle in SERVE; serve counter loads SERVE_TICKS.
REQ-019 SERVE: serve counter decrements on each internal tick; on the tick that brings it to 0 -> PLAY; presses ignored in SERVE.
REQ-020 PLAY: a life loss is detected when lives < lives_q (lives_q is lives registered every cycle); life_lost pulses in the same cycle as the transition.
REQ-021 PLAY, life loss with lives==0 -> OVER; with lives!=0 -> SERVE.
REQ-022 PLAY, visible all zeros -> WIN; WIN has priority over simultaneous life loss (life_lost still pulses).
REQ-023 PLAY, press -> PAUSED when no life loss or win in that cycle; win/life loss take priority over press.
REQ-024 PAUSED: press -> PLAY; life-loss and win checks suspended; lives_q keeps tracking lives.
REQ-025 WIN and OVER: press -> IDLE; no other exits.
REQ-026 Score: visible_q registered every cycle; in SERVE, PLAY, PAUSED, score += popcount(visible_q & ~visible), result clamped to NUM_BLOCKS; multiple blocks cleared in one cycle all count.
REQ-027 Block reappearance (0->1 in visible) never decrements score.
REQ-028 An increase of lives (e.g. 0->3 wrap from the ball block) is not a life loss.
REQ-029 All outputs registered; life_lost and ball_reset never asserted for more than one consecutive cycle.

Reset
REQ-030 While rst==0: game_state=IDLE, step_tick=0, ball_reset=0, life_lost=0, score=0, divider=0, serve counter=0, start_q=0, lives_q=lives input, visible_q=all ones.
REQ-031 Reset asserted mid-game aborts immediately to IDLE; first press after release starts a new game with score 0.

Verification (TICK_DIV=4, SERVE_TICKS=2, NUM_BLOCKS=56)
REQ-032 Reset release, start press -> SERVE, ball_reset high 1 cycle, PLAY after 8 cycles, then step_tick every 4th cycle.
REQ-033 In PLAY, lives 3->2 -> life_lost 1 cycle, SERVE, ball_reset 1 cycle; lives 1->0 -> life_lost, OVER, step_tick stays 0.
REQ-034 In PLAY, visible drops 3 bits in one cycle -> score +3; clear remaining bits -> score 56, WIN; same-cycle lives 1->0 still ends in WIN.
REQ-035 Press in PLAY -> PAUSED, no step_tick for 20 cycles, press -> PLAY, next tick resumes from held divider count.
REQ-036 start held high 100 cycles in IDLE -> exactly one transition; rst pulsed low in PLAY -> IDLE, score 0, all pulses low.
